// File: rtl/cache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the core LSU and
// a slower line-oriented backing memory.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   core_req_i, add_i, wen_i,       core access request (held until core_ack_o),
//   wdata_i                         byte address, byte write enables, store data
//   rdata_o, core_ack_o             load data (pre-write value on stores), done pulse
//   mem_req_valid_o/ready_i/we_o/   line request handshake: we=1 writeback,
//   add_o                           we=0 refill, line-aligned byte address
//   mem_wdata_o/wvalid_o/wready_i   writeback beats
//   mem_rdata_i/rvalid_i            refill beats (no backpressure)
module cache_dm_wb #(
    parameter int unsigned ADD_WIDTH  = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 core_req_i,
    input  logic [ADD_WIDTH-1:0] add_i,
    input  logic [3:0]           wen_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 core_ack_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic                 mem_req_we_o,
    output logic [ADD_WIDTH-1:0] mem_req_add_o,
    output logic [31:0]          mem_wdata_o,
    output logic                 mem_wvalid_o,
    input  logic                 mem_wready_i,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 mem_rvalid_i
);

    localparam int unsigned OffW = $clog2(LINE_WORDS);
    localparam int unsigned IdxW = $clog2(SETS);
    localparam int unsigned TagW = ADD_WIDTH - IdxW - OffW - 2;
    localparam logic [OffW-1:0] LastBeat = OffW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle, StCompare, StWbReq, StWbData, StFillReq, StFillData
    } state_e;

    // Storage: data and tags have no reset; valid/dirty are flops cleared by reset.
    logic [31:0]     data_mem [SETS*LINE_WORDS];
    logic [TagW-1:0] tag_mem  [SETS];
    logic [SETS-1:0] valid_q, dirty_q;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [TagW-1:0] tag_q, tag_d;        // requested tag
    logic [OffW-1:0] off_q, off_d;
    logic [TagW-1:0] st_tag_q, st_tag_d;  // stored tag of the indexed set
    logic            st_valid_q, st_valid_d;
    logic            st_dirty_q, st_dirty_d;
    logic [31:0]     word_q, word_d;      // addressed word as currently held in the line
    logic [OffW-1:0] cnt_q, cnt_d;

    logic [IdxW-1:0] req_idx;
    logic [TagW-1:0] req_tag;
    logic [OffW-1:0] req_off;
    logic            hit;
    logic [31:0]     merged;
    logic            dwe, tag_we, set_dirty, clr_dirty;
    logic [IdxW+OffW-1:0] dwaddr;
    logic [31:0]     dwdata;
    logic            unused_add;

    assign req_off    = add_i[OffW+1:2];
    assign req_idx    = add_i[OffW+IdxW+1:OffW+2];
    assign req_tag    = add_i[ADD_WIDTH-1:OffW+IdxW+2];
    assign unused_add = ^add_i[1:0];
    assign hit        = st_valid_q && (st_tag_q == tag_q);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen_i[i] ? wdata_i[8*i +: 8] : word_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        off_d      = off_q;
        st_tag_d   = st_tag_q;
        st_valid_d = st_valid_q;
        st_dirty_d = st_dirty_q;
        word_d     = word_q;
        cnt_d      = cnt_q;

        core_ack_o      = 1'b0;
        rdata_o         = '0;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_add_o   = '0;
        mem_wvalid_o    = 1'b0;
        mem_wdata_o     = '0;

        dwe       = 1'b0;
        dwaddr    = {idx_q, off_q};
        dwdata    = merged;
        tag_we    = 1'b0;
        set_dirty = 1'b0;
        clr_dirty = 1'b0;

        case (state_q)
            StIdle: begin
                if (core_req_i) begin
                    idx_d      = req_idx;
                    tag_d      = req_tag;
                    off_d      = req_off;
                    st_tag_d   = tag_mem[req_idx];
                    st_valid_d = valid_q[req_idx];
                    st_dirty_d = dirty_q[req_idx];
                    word_d     = data_mem[{req_idx, req_off}];
                    state_d    = StCompare;
                end
            end
            StCompare: begin
                if (hit) begin
                    core_ack_o = 1'b1;
                    rdata_o    = word_q;
                    if (wen_i != 4'b0000) begin
                        dwe       = 1'b1;
                        set_dirty = 1'b1;
                    end
                    state_d = StIdle;
                end else if (st_valid_q && st_dirty_q) begin
                    state_d = StWbReq;
                end else begin
                    state_d = StFillReq;
                end
            end
            StWbReq: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_add_o   = {st_tag_q, idx_q, {(OffW + 2){1'b0}}};
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = StWbData;
                end
            end
            StWbData: begin
                mem_wvalid_o = 1'b1;
                mem_wdata_o  = data_mem[{idx_q, cnt_q}];
                if (mem_wready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastBeat) begin
                        clr_dirty = 1'b1;
                        state_d   = StFillReq;
                    end
                end
            end
            StFillReq: begin
                mem_req_valid_o = 1'b1;
                mem_req_add_o   = {tag_q, idx_q, {(OffW + 2){1'b0}}};
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = StFillData;
                end
            end
            StFillData: begin
                if (mem_rvalid_i) begin
                    dwe    = 1'b1;
                    dwaddr = {idx_q, cnt_q};
                    dwdata = mem_rdata_i;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == off_q) word_d = mem_rdata_i;
                    if (cnt_q == LastBeat) begin
                        // Line is now resident and clean; re-run COMPARE as a hit.
                        tag_we     = 1'b1;
                        st_tag_d   = tag_q;
                        st_valid_d = 1'b1;
                        st_dirty_d = 1'b0;
                        state_d    = StCompare;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            tag_q      <= '0;
            off_q      <= '0;
            st_tag_q   <= '0;
            st_valid_q <= 1'b0;
            st_dirty_q <= 1'b0;
            word_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            off_q      <= off_d;
            st_tag_q   <= st_tag_d;
            st_valid_q <= st_valid_d;
            st_dirty_q <= st_dirty_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            if (set_dirty) dirty_q[idx_q] <= 1'b1;
            if (clr_dirty) dirty_q[idx_q] <= 1'b0;
            if (tag_we) begin
                valid_q[idx_q] <= 1'b1;
                dirty_q[idx_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dwe)    data_mem[dwaddr] <= dwdata;
        if (tag_we) tag_mem[idx_q]   <= tag_q;
    end

endmodule

// File: tb/tb_cache_dm_wb.sv
module tb_cache_dm_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic [31:0] add;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        core_ack;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_add;
    logic [31:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_dm_wb #(
        .ADD_WIDTH (32),
        .LINE_WORDS(4),
        .SETS      (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .core_req_i     (core_req),
        .add_i          (add),
        .wen_i          (wen),
        .wdata_i        (wdata),
        .rdata_o        (rdata),
        .core_ack_o     (core_ack),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready),
        .mem_req_we_o   (mem_req_we),
        .mem_req_add_o  (mem_req_add),
        .mem_wdata_o    (mem_wdata),
        .mem_wvalid_o   (mem_wvalid),
        .mem_wready_i   (mem_wready),
        .mem_rdata_i    (mem_rdata),
        .mem_rvalid_i   (mem_rvalid)
    );

    typedef struct {
        logic [31:0]      add;
        logic [3:0]       wen;
        logic [31:0]      wdata;
        logic [31:0]      exp_rdata;
        bit               exp_wb;
        logic [31:0]      wb_add;
        logic [3:0][31:0] wb_data;
        bit               exp_fill;
        logic [31:0]      fill_add;
        logic [3:0][31:0] fill_data;
        bit               bp;           // request stalls + wready/rvalid gaps
        int               fill_abort;   // stop after this many refill beats (0 = never)
        bit               reset_after;
    } vec_t;

    vec_t vq[$];

    function automatic logic [3:0][31:0] w4(input logic [31:0] a, b, c, d);
        logic [3:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_mem();
        mem_req_ready = 1'b0;
        mem_wready    = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic chk_outputs_zero();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_core_ack", {31'b0, core_ack}, 32'h0);
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_mem_wvalid", {31'b0, mem_wvalid}, 32'h0);
        chk("rst_mem_req_we", {31'b0, mem_req_we}, 32'h0);
        chk("rst_mem_req_add", mem_req_add, 32'h0);
    endtask

    // Called at a negedge; drives one core access and plays the memory side.
    task automatic run_vec(input vec_t v);
        int  cyc = 0;
        int  wbeat = 0;
        int  fbeat = 0;
        int  stall = 0;
        bit  fill_go = 1'b0;
        bit  tog = 1'b1;
        bit  done = 1'b0;
        logic [31:0] exp_kind;
        core_req = 1'b1;
        add      = v.add;
        wen      = v.wen;
        wdata    = v.wdata;
        while (!done) begin
            @(negedge clk);
            cyc++;
            idle_mem();
            if (core_ack) begin
                chk("rdata", rdata, v.exp_rdata);
                chk("wb_beats", wbeat, v.exp_wb ? 32'd4 : 32'd0);
                chk("fill_beats", fbeat, v.exp_fill ? 32'd4 : 32'd0);
                if (!v.exp_wb && !v.exp_fill) chk("hit_latency", cyc, 32'd1);
                core_req = 1'b0;
                done     = 1'b1;
                @(negedge clk);
                chk("ack_pulse", {31'b0, core_ack}, 32'h0);
            end else if (v.fill_abort != 0 && fbeat == v.fill_abort) begin
                done = 1'b1;
            end else if (cyc > 200) begin
                checks++;
                errors++;
                $display("FAIL timeout: add %h no core_ack after %0d cycles", v.add, cyc);
                core_req = 1'b0;
                done     = 1'b1;
            end else begin
                if (mem_req_valid) begin
                    exp_kind = (v.exp_wb && wbeat < 4) ? 32'd1 : 32'd0;
                    chk("req_we", {31'b0, mem_req_we}, exp_kind);
                    chk("req_add", mem_req_add, exp_kind[0] ? v.wb_add : v.fill_add);
                    if (v.bp && stall < 5) begin
                        stall++;
                    end else begin
                        mem_req_ready = 1'b1;
                        stall = 0;
                        if (!mem_req_we) fill_go = 1'b1;
                    end
                end else if (mem_wvalid) begin
                    if (!v.exp_wb || wbeat >= 4) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_extra_beat: beat %0d seen, allowed %0d",
                                 wbeat, v.exp_wb ? 4 : 0);
                    end else begin
                        chk("wb_data", mem_wdata, v.wb_data[wbeat]);
                    end
                    mem_wready = v.bp ? tog : 1'b1;
                    tog = ~tog;
                    if (mem_wready) wbeat++;
                end else if (fill_go && fbeat < 4) begin
                    if (!v.bp || tog) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.fill_data[fbeat];
                        fbeat++;
                    end
                    tog = ~tog;
                end
                // Stray refill beats before the refill phase must be ignored.
                if (v.bp && !fill_go) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hBAD0BAD0;
                end
            end
        end
        idle_mem();
    endtask

    initial begin
        reset    = 1'b1;
        core_req = 1'b0;
        add      = '0;
        wen      = '0;
        wdata    = '0;
        idle_mem();

        // add, wen, wdata, exp_rdata, wb?, wb_add, wb_data, fill?, fill_add, fill_data,
        // bp, fill_abort, reset_after
        vq.push_back('{32'h104, 4'h0, 32'h0, 32'h22, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b1, 32'h100, w4(32'h11, 32'h22, 32'h33, 32'h44), 1'b0, 0, 1'b0});
        vq.push_back('{32'h10C, 4'h0, 32'h0, 32'h44, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b0, 32'h0, w4(0, 0, 0, 0), 1'b0, 0, 1'b0});
        vq.push_back('{32'h108, 4'b0010, 32'hAABBCCDD, 32'h33, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b0, 32'h0, w4(0, 0, 0, 0), 1'b0, 0, 1'b0});
        vq.push_back('{32'h108, 4'h0, 32'h0, 32'h0000CC33, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b0, 32'h0, w4(0, 0, 0, 0), 1'b0, 0, 1'b0});
        vq.push_back('{32'h500, 4'h0, 32'h0, 32'h55,
                       1'b1, 32'h100, w4(32'h11, 32'h22, 32'h0000CC33, 32'h44),
                       1'b1, 32'h500, w4(32'h55, 32'h66, 32'h77, 32'h88), 1'b1, 0, 1'b0});
        vq.push_back('{32'h104, 4'h0, 32'h0, 32'hA2, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b1, 32'h100, w4(32'hA1, 32'hA2, 32'hA3, 32'hA4), 1'b0, 0, 1'b0});
        vq.push_back('{32'h204, 4'hF, 32'hDEADBEEF, 32'h2, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b1, 32'h200, w4(32'h1, 32'h2, 32'h3, 32'h4), 1'b0, 0, 1'b0});
        vq.push_back('{32'h204, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b0, 32'h0, w4(0, 0, 0, 0), 1'b0, 0, 1'b0});
        vq.push_back('{32'h604, 4'h0, 32'h0, 32'hC2,
                       1'b1, 32'h200, w4(32'h1, 32'hDEADBEEF, 32'h3, 32'h4),
                       1'b1, 32'h600, w4(32'hC1, 32'hC2, 32'hC3, 32'hC4), 1'b1, 0, 1'b0});
        vq.push_back('{32'h100, 4'hF, 32'h12345678, 32'hA1, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b0, 32'h0, w4(0, 0, 0, 0), 1'b0, 0, 1'b0});
        vq.push_back('{32'h900, 4'h0, 32'h0, 32'h0,
                       1'b1, 32'h100, w4(32'h12345678, 32'hA2, 32'hA3, 32'hA4),
                       1'b1, 32'h900, w4(32'hE1, 32'hE2, 32'hE3, 32'hE4), 1'b0, 2, 1'b1});
        vq.push_back('{32'h100, 4'h0, 32'h0, 32'hB1, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b1, 32'h100, w4(32'hB1, 32'hB2, 32'hB3, 32'hB4), 1'b0, 0, 1'b0});
        vq.push_back('{32'h50C, 4'h0, 32'h0, 32'hD4, 1'b0, 32'h0, w4(0, 0, 0, 0),
                       1'b1, 32'h500, w4(32'hD1, 32'hD2, 32'hD3, 32'hD4), 1'b1, 0, 1'b0});

        repeat (3) @(negedge clk);
        chk_outputs_zero();
        reset = 1'b0;

        foreach (vq[i]) begin
            run_vec(vq[i]);
            if (vq[i].reset_after) begin
                reset    = 1'b1;
                core_req = 1'b0;
                @(negedge clk);
                chk_outputs_zero();
                reset = 1'b0;
            end
        end

        // Idle cache with no request must stay quiet on both sides.
        repeat (3) begin
            @(negedge clk);
            chk("idle_req_valid", {31'b0, mem_req_valid}, 32'h0);
            chk("idle_ack", {31'b0, core_ack}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
